// File: rtl/mem_access_ctrl.sv
// Load/store access controller between an RV32I core and a word-wide memory bus.
// It accepts one request at a time, rejects illegal funct3 codes and misaligned
// addresses without touching the bus, and otherwise issues one word-aligned bus
// access with byte strobes and lane-replicated store data. A missing mem_ack
// ends in a bus timeout. Every request ends with a one-cycle response pulse.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_we, req_funct          store flag, RV32I funct3
//   req_addr, req_wdata        byte address, right-aligned store data
//   mem_req/mem_ack            bus request (held until ack) / one-cycle completion
//   mem_we, mem_addr           bus write enable, word-aligned address
//   mem_wstrb, mem_wdata       byte enables, lane-replicated store data
//   mem_rdata                  raw read word, valid with mem_ack
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata                  raw read word for the load extender
//   rsp_offset, rsp_funct      address offset and funct3 for the load extender
//   rsp_err, rsp_cause         failure flag; 01 misaligned, 10 illegal, 11 timeout
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_offset,
  output logic [2:0]  rsp_funct,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    BUS   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        funct_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  // bus_done marks the single drain cycle after ack/timeout, with mem_req already low
  logic              bus_done;
  logic              bus_timeout;

  logic              illegal;
  logic              misalign;
  logic [3:0]        wstrb_calc;
  logic [31:0]       wdata_calc;

  assign wait_nxt = wait_cnt + CNT_W'(1);

  // Request legality and bus lane formatting from the captured request.
  always_comb begin
    illegal    = 1'b0;
    misalign   = 1'b0;
    wstrb_calc = 4'b0000;
    wdata_calc = wdata_q;
    if (we_q) begin
      illegal = funct_q[2] | (funct_q[1:0] == 2'b11);
    end else begin
      illegal = (funct_q == 3'b011) | (funct_q == 3'b110) | (funct_q == 3'b111);
    end
    misalign = ((funct_q[1:0] == 2'b01) && addr_q[0]) ||
               ((funct_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    if (we_q) begin
      case (funct_q[1:0])
        2'b00: begin
          wstrb_calc = 4'b0001 << addr_q[1:0];
          wdata_calc = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          wstrb_calc = 4'b0011 << addr_q[1:0];
          wdata_calc = {2{wdata_q[15:0]}};
        end
        default: begin
          wstrb_calc = 4'b1111;
          wdata_calc = wdata_q;
        end
      endcase
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      we_q        <= 1'b0;
      funct_q     <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wait_cnt    <= '0;
      bus_done    <= 1'b0;
      bus_timeout <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= 32'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_offset  <= 2'b00;
      rsp_funct   <= 3'b000;
      rsp_err     <= 1'b0;
      rsp_cause   <= CAUSE_NONE;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            funct_q   <= req_funct;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= CHECK;
          end
        end

        CHECK: begin
          if (illegal || misalign) begin
            // Rejected requests respond immediately and never reach the bus
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_cause  <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            rsp_offset <= addr_q[1:0];
            rsp_funct  <= funct_q;
          end else begin
            state       <= BUS;
            mem_req     <= 1'b1;
            mem_we      <= we_q;
            mem_addr    <= {addr_q[31:2], 2'b00};
            mem_wstrb   <= wstrb_calc;
            mem_wdata   <= wdata_calc;
            wait_cnt    <= '0;
            bus_done    <= 1'b0;
            bus_timeout <= 1'b0;
          end
        end

        BUS: begin
          if (bus_done) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_err    <= bus_timeout;
            rsp_cause  <= bus_timeout ? CAUSE_TIMEOUT : CAUSE_NONE;
            rsp_offset <= addr_q[1:0];
            rsp_funct  <= funct_q;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
          end else if (mem_ack) begin
            // Ack wins over a simultaneous timeout
            if (!we_q) begin
              rsp_rdata <= mem_rdata;
            end
            mem_req  <= 1'b0;
            bus_done <= 1'b1;
          end else if (wait_nxt == TIMEOUT_CNT) begin
            wait_cnt    <= wait_nxt;
            mem_req     <= 1'b0;
            bus_done    <= 1'b1;
            bus_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end

        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset values, loads/stores, CHECK
// errors, bus timeout, ack/timeout collision and mid-transaction reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_offset;
  logic [2:0]  rsp_funct;
  logic        rsp_err;
  logic [1:0]  rsp_cause;

  int total = 0;
  int bad   = 0;

  // Observations captured during a transaction
  int          lat;
  int          bus_cycles;
  logic        b_we;
  logic [31:0] b_addr;
  logic [3:0]  b_strb;
  logic [31:0] b_wdata;

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct  (req_funct),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_offset (rsp_offset),
    .rsp_funct  (rsp_funct),
    .rsp_err    (rsp_err),
    .rsp_cause  (rsp_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, ack on BUS cycle ack_at (0 = never), run to rsp_valid.
  task automatic run_txn(input logic we, input logic [2:0] funct, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct  = funct;
    req_addr   = addr;
    req_wdata  = wdata;
    lat        = 0;
    bus_cycles = 0;
    b_we = 1'b0; b_addr = 32'h0; b_strb = 4'h0; b_wdata = 32'h0;
    step();
    req_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      mem_ack = 1'b0;
      if (rsp_valid) begin
        lat = n;
        break;
      end
      if (mem_req) begin
        bus_cycles++;
        if (bus_cycles == 1) begin
          b_we = mem_we; b_addr = mem_addr; b_strb = mem_wstrb; b_wdata = mem_wdata;
        end
        if (bus_cycles == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  // RESP lasts one cycle, then the block is ready again
  task automatic after_rsp(input string tag);
    step();
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cause", 32'(rsp_cause), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_offset", 32'(rsp_offset), 32'd0);
    chk("rst_funct", 32'(rsp_funct), 32'd0);

    // LBU at 0x1003, ack on first BUS cycle
    run_txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 1, 32'hA1B2_C3D4);
    chk("lbu_lat", 32'(lat), 32'd4);
    chk("lbu_bus_cycles", 32'(bus_cycles), 32'd1);
    chk("lbu_addr", b_addr, 32'h0000_1000);
    chk("lbu_we", 32'(b_we), 32'd0);
    chk("lbu_strb", 32'(b_strb), 32'd0);
    chk("lbu_rdata", rsp_rdata, 32'hA1B2_C3D4);
    chk("lbu_offset", 32'(rsp_offset), 32'd3);
    chk("lbu_funct", 32'(rsp_funct), 32'd4);
    chk("lbu_err", 32'(rsp_err), 32'd0);
    chk("lbu_cause", 32'(rsp_cause), 32'd0);
    after_rsp("lbu");
    chk("lbu_rdata_hold", rsp_rdata, 32'hA1B2_C3D4);

    // SB at 0x2002; rsp_rdata must keep the previous load word
    run_txn(1'b1, 3'b000, 32'h0000_2002, 32'h0000_00EE, 1, 32'h5555_5555);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_we", 32'(b_we), 32'd1);
    chk("sb_addr", b_addr, 32'h0000_2000);
    chk("sb_strb", 32'(b_strb), 32'h4);
    chk("sb_wdata", b_wdata, 32'hEEEE_EEEE);
    chk("sb_err", 32'(rsp_err), 32'd0);
    chk("sb_rdata_kept", rsp_rdata, 32'hA1B2_C3D4);
    after_rsp("sb");

    // SH at 0x2002
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 1, 32'h0);
    chk("sh_strb", 32'(b_strb), 32'hC);
    chk("sh_wdata", b_wdata, 32'hBEEF_BEEF);
    chk("sh_err", 32'(rsp_err), 32'd0);
    after_rsp("sh");

    // SW at 0x2004
    run_txn(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 1, 32'h0);
    chk("sw_strb", 32'(b_strb), 32'hF);
    chk("sw_wdata", b_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", b_addr, 32'h0000_2004);
    after_rsp("sw");

    // LW with ack on third BUS cycle
    run_txn(1'b0, 3'b010, 32'h0000_4000, 32'h0, 3, 32'h0BAD_F00D);
    chk("lw3_lat", 32'(lat), 32'd6);
    chk("lw3_bus_cycles", 32'(bus_cycles), 32'd3);
    chk("lw3_rdata", rsp_rdata, 32'h0BAD_F00D);
    after_rsp("lw3");

    // LW misaligned
    run_txn(1'b0, 3'b010, 32'h0000_3002, 32'h0, 1, 32'h0);
    chk("lwmis_lat", 32'(lat), 32'd2);
    chk("lwmis_bus", 32'(bus_cycles), 32'd0);
    chk("lwmis_err", 32'(rsp_err), 32'd1);
    chk("lwmis_cause", 32'(rsp_cause), 32'd1);
    chk("lwmis_offset", 32'(rsp_offset), 32'd2);
    after_rsp("lwmis");

    // LH odd offset misaligned
    run_txn(1'b0, 3'b001, 32'h0000_3001, 32'h0, 1, 32'h0);
    chk("lhmis_cause", 32'(rsp_cause), 32'd1);
    chk("lhmis_bus", 32'(bus_cycles), 32'd0);
    after_rsp("lhmis");

    // Load funct 011 illegal
    run_txn(1'b0, 3'b011, 32'h0000_3000, 32'h0, 1, 32'h0);
    chk("ld011_lat", 32'(lat), 32'd2);
    chk("ld011_cause", 32'(rsp_cause), 32'd2);
    chk("ld011_bus", 32'(bus_cycles), 32'd0);
    after_rsp("ld011");

    // Store funct 100 illegal
    run_txn(1'b1, 3'b100, 32'h0000_3000, 32'h0, 1, 32'h0);
    chk("st100_cause", 32'(rsp_cause), 32'd2);
    chk("st100_err", 32'(rsp_err), 32'd1);
    chk("st100_bus", 32'(bus_cycles), 32'd0);
    after_rsp("st100");

    // Store funct 110 at offset 1: illegal outranks misaligned
    run_txn(1'b1, 3'b110, 32'h0000_3001, 32'h0, 1, 32'h0);
    chk("prio_cause", 32'(rsp_cause), 32'd2);
    after_rsp("prio");

    // LH with no ack: 15 cycles of mem_req, then timeout
    run_txn(1'b0, 3'b001, 32'h0000_6002, 32'h0, 0, 32'h0);
    chk("to_bus_cycles", 32'(bus_cycles), 32'd15);
    chk("to_lat", 32'(lat), 32'd18);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_cause", 32'(rsp_cause), 32'd3);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    after_rsp("to");

    // LH with ack on the 15th BUS cycle: ack beats timeout
    run_txn(1'b0, 3'b001, 32'h0000_6002, 32'h0, 15, 32'hCAFE_1234);
    chk("ack15_bus_cycles", 32'(bus_cycles), 32'd15);
    chk("ack15_err", 32'(rsp_err), 32'd0);
    chk("ack15_cause", 32'(rsp_cause), 32'd0);
    chk("ack15_rdata", rsp_rdata, 32'hCAFE_1234);
    after_rsp("ack15");

    // Reset on the third BUS cycle, late ack afterwards
    req_valid = 1'b1; req_we = 1'b0; req_funct = 3'b001;
    req_addr = 32'h0000_5000; req_wdata = 32'h0;
    step();
    req_valid = 1'b0;
    step();
    chk("mrst_bus1", 32'(mem_req), 32'd1);
    step();
    step();
    chk("mrst_bus3", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    chk("mrst_mem_req", 32'(mem_req), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || mem_req) seen++;
      step();
      mem_ack = 1'b0;
    end
    chk("mrst_no_rsp", 32'(seen), 32'd0);
    chk("mrst_ready_end", 32'(req_ready), 32'd1);
    chk("mrst_rdata", rsp_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUS-state cycles without mem_ack before a bus error (range 1..255).
REQ-002 SHALL have the following ports; the clock domain is one clock, and reset is synchronous and active-high:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a load/store request.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct  in  3  RV32I funct3 (loads 000/001/010/100/101; stores 000/001/010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  req_addr with bits [1:0] forced to 00.
- mem_wstrb  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completion, one-cycle pulse.
- mem_rdata  in  32  raw read word, valid with mem_ack.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  raw captured read word, unshifted, feeding the load extender's data_in.
- rsp_offset  out  2  req_addr[1:0], feeding the load extender's address input.
- rsp_funct  out  3  echoed funct, feeding the load extender's funct input.
- rsp_err  out  1  request failed.
- rsp_cause  out  2  00 none, 01 misaligned, 10 illegal funct, 11 bus timeout.

Function
REQ-003 SHALL implement a four-state FSM with states IDLE, CHECK, BUS and RESP.
REQ-004 SHALL drive req_ready high only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high, and the block SHALL register req_we, req_funct, req_addr and req_wdata, then move to CHECK.
REQ-005 SHALL flag illegal funct in CHECK: loads other than 000/001/010/100/101, and stores other than 000/001/010.
REQ-006 SHALL flag misalignment in CHECK: half-word (funct[1:0]=01) with offset[0]=1, or word (funct[1:0]=10) with offset not equal to 00.
REQ-007 SHALL give illegal funct priority over misalignment when both apply.
REQ-008 SHALL, on any CHECK error, go directly to RESP with rsp_err=1 and SHALL NOT assert mem_req; otherwise it SHALL go to BUS.
REQ-009 SHALL, in BUS, hold mem_req=1 and hold mem_we, mem_addr, mem_wstrb and mem_wdata stable until mem_ack.
REQ-010 SHALL drive mem_wstrb as follows: SB = 0001 shifted left by offset; SH = 0011 shifted left by offset; SW = 1111; loads = 0000.
REQ-011 SHALL drive mem_wdata as follows: SB = byte [7:0] replicated 4 times; SH = half-word [15:0] replicated 2 times; SW = req_wdata.
REQ-012 SHALL, on mem_ack in BUS, capture mem_rdata into rsp_rdata for loads (rsp_rdata is unchanged for stores), deassert mem_req on the next cycle, and go to RESP.
REQ-013 SHALL keep an 8-bit wait counter that clears on entry to BUS and increments on each BUS cycle without mem_ack.
REQ-014 SHALL, when the wait counter reaches TIMEOUT without mem_ack, deassert mem_req and go to RESP with cause 11.
REQ-015 SHALL give mem_ack priority over timeout when both occur in the same cycle (completion, no error).
REQ-016 SHALL ignore mem_ack outside BUS.
REQ-017 SHALL, in RESP, assert rsp_valid for exactly one cycle with rsp_offset, rsp_funct, rsp_err and rsp_cause valid, then return to IDLE.
REQ-018 SHALL hold rsp_rdata, rsp_offset and rsp_funct until the next response.
REQ-019 SHALL give a minimum load/store latency of 4 cycles from acceptance to rsp_valid when mem_ack arrives on the first BUS cycle.
REQ-020 SHALL give an error latency of 2 cycles from acceptance to rsp_valid for CHECK errors.
REQ-021 SHALL sustain at most one outstanding request; back-to-back requests are accepted no earlier than the cycle after RESP.

Reset
REQ-022 SHALL, while reset is high at a clock edge, set the state to IDLE.
REQ-023 SHALL reset to: req_ready=1 after reset; mem_req=0; mem_we=0; mem_wstrb=0000; rsp_valid=0; rsp_err=0; rsp_cause=00; wait counter=0; mem_addr, mem_wdata, rsp_rdata, rsp_offset and rsp_funct all 0.
REQ-024 SHALL, when reset is asserted mid-transaction, deassert mem_req on the next edge, produce no rsp_valid for the aborted request, and ignore any late mem_ack.

Verification
REQ-025 SHALL pass: LBU at 0x0000_1003, mem_ack on the 1st BUS cycle with mem_rdata=0xA1B2C3D4 -> rsp_valid 4 cycles after accept, rsp_rdata=0xA1B2C3D4, rsp_offset=11, rsp_funct=100, rsp_err=0, mem_addr=0x0000_1000.
REQ-026 SHALL pass: SB at 0x0000_2002 with wdata=0x0000_00EE -> mem_we=1, mem_wstrb=0100, mem_wdata=0xEEEEEEEE, rsp_err=0.
REQ-027 SHALL pass: LW at 0x0000_3002 -> no mem_req, rsp_valid 2 cycles after accept, rsp_err=1, rsp_cause=01.
REQ-028 SHALL pass: load funct 011 -> rsp_cause=10; store funct 100 -> rsp_cause=10; no bus activity in either case.
REQ-029 SHALL pass: LH with no mem_ack and TIMEOUT=15 -> mem_req high for 15 cycles then low, rsp_cause=11; repeated with mem_ack on the 15th BUS cycle -> rsp_err=0.
REQ-030 SHALL pass: reset asserted on the 3rd BUS cycle, then mem_ack one cycle later -> mem_req=0, no rsp_valid, req_ready=1.
